// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port around dm_arbiter.
// slave  : the arbiter's view (requests and memory read data come in).
// master : the environment's view (pipeline, DMA engine and memory model).
interface dm_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  // port 0: pipeline MEM stage
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt;
  logic          p0_stall;
  logic          p0_rvalid;
  logic [DW-1:0] p0_rdata;

  // port 1: DMA / vector-load engine
  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_lock;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [DW-1:0] p1_rdata;

  // single-ported data memory
  logic          dm_rd;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_stall, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
    output p1_gnt, p1_rvalid, p1_rdata,
    output dm_rd, dm_wr, dm_addr, dm_wdata,
    input  dm_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_stall, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  dm_rd, dm_wr, dm_addr, dm_wdata,
    output dm_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-ported data memory.
// Port 0 (pipeline) normally wins; port 1 (DMA) is protected from starvation
// by a saturating wait counter and may stream words under a bounded lock.
// Grants are combinational within the cycle; read data returns one cycle later.
module dm_arbiter #(
  parameter int AW        = 7,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  dm_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [3:0] WAIT_MAX_C  = 4'(MAX_WAIT);
  localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);

  state_t        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [7:0]    burst_cnt_q, burst_cnt_d;
  logic          holdoff_q, holdoff_d;
  logic          p0_rvalid_q, p0_rvalid_d;
  logic          p1_rvalid_q, p1_rvalid_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;

  logic          p0_gnt_s;
  logic          p1_gnt_s;
  logic          dm_rd_s;
  logic          dm_wr_s;
  logic [AW-1:0] dm_addr_s;
  logic [DW-1:0] dm_wdata_s;

  // Grant selection: starvation override, then lock, then port 0, then port 1.
  always_comb begin
    p0_gnt_s = 1'b0;
    p1_gnt_s = 1'b0;
    if (rst) begin
      p0_gnt_s = 1'b0;
      p1_gnt_s = 1'b0;
    end else if (bus.p1_req && (wait_cnt_q == WAIT_MAX_C)) begin
      p1_gnt_s = 1'b1;
    end else if ((state_q == LOCK) && bus.p1_req) begin
      p1_gnt_s = 1'b1;
    end else if (bus.p0_req) begin
      p0_gnt_s = 1'b1;
    end else if (bus.p1_req) begin
      p1_gnt_s = 1'b1;
    end else begin
      p0_gnt_s = 1'b0;
      p1_gnt_s = 1'b0;
    end
  end

  // Memory port mux: the granted requester drives the bus, otherwise all zero.
  always_comb begin
    dm_rd_s    = 1'b0;
    dm_wr_s    = 1'b0;
    dm_addr_s  = '0;
    dm_wdata_s = '0;
    case ({p1_gnt_s, p0_gnt_s})
      2'b01: begin
        dm_rd_s    = ~bus.p0_we;
        dm_wr_s    = bus.p0_we;
        dm_addr_s  = bus.p0_addr;
        dm_wdata_s = bus.p0_wdata;
      end
      2'b10: begin
        dm_rd_s    = ~bus.p1_we;
        dm_wr_s    = bus.p1_we;
        dm_addr_s  = bus.p1_addr;
        dm_wdata_s = bus.p1_wdata;
      end
      default: begin
        dm_rd_s    = 1'b0;
        dm_wr_s    = 1'b0;
        dm_addr_s  = '0;
        dm_wdata_s = '0;
      end
    endcase
  end

  // Starvation counter: counts consecutive denied port-1 requests, saturating.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.p1_req || p1_gnt_s) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < WAIT_MAX_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Burst lock FSM: enter on a locked port-1 grant, leave on drop, unlock or
  // after BURST_MAX locked beats; a forced release arms a one-cycle holdoff.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    holdoff_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (p1_gnt_s && bus.p1_lock && !(holdoff_q && bus.p0_req)) begin
          state_d     = LOCK;
          burst_cnt_d = 8'd1;
        end else begin
          state_d     = IDLE;
        end
      end
      LOCK: begin
        if (!bus.p1_req) begin
          state_d     = IDLE;
          burst_cnt_d = 8'd0;
        end else if (p1_gnt_s && !bus.p1_lock) begin
          state_d     = IDLE;
          burst_cnt_d = 8'd0;
        end else if (p1_gnt_s && (burst_cnt_q == BURST_MAX_C)) begin
          state_d     = IDLE;
          burst_cnt_d = 8'd0;
          holdoff_d   = 1'b1;
        end else if (p1_gnt_s) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end else begin
          state_d     = LOCK;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = 8'd0;
      end
    endcase
  end

  // Read return: capture memory data on a granted read, hold it otherwise.
  always_comb begin
    p0_rvalid_d = p0_gnt_s & ~bus.p0_we;
    p1_rvalid_d = p1_gnt_s & ~bus.p1_we;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    if (p0_rvalid_d) begin
      p0_rdata_d = bus.dm_rdata;
    end else begin
      p0_rdata_d = p0_rdata_q;
    end
    if (p1_rvalid_d) begin
      p1_rdata_d = bus.dm_rdata;
    end else begin
      p1_rdata_d = p1_rdata_q;
    end
  end

  // State and data registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      burst_cnt_q <= 8'd0;
      holdoff_q   <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      holdoff_q   <= holdoff_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign bus.p0_gnt    = p0_gnt_s;
  assign bus.p1_gnt    = p1_gnt_s;
  assign bus.p0_stall  = bus.p0_req & ~p0_gnt_s & ~rst;
  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.dm_rd     = dm_rd_s;
  assign bus.dm_wr     = dm_wr_s;
  assign bus.dm_addr   = dm_addr_s;
  assign bus.dm_wdata  = dm_wdata_s;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a driver applies stimulus after each rising
// edge and pushes the reference model's expected cycle response; a monitor pops
// and compares on each falling edge.
module tb_dm_arbiter;

  localparam int AW        = 7;
  localparam int DW        = 32;
  localparam int MAX_WAIT  = 4;
  localparam int BURST_MAX = 8;

  logic clk;
  logic rst;

  dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dm_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- memory seen by the DUT ----------------
  logic [DW-1:0] mem [0:127];

  function automatic logic [DW-1:0] seed_word(input int i);
    logic [DW-1:0] w;
    w = (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
    if (i == 5) w = 32'hDEAD_BEEF;
    return w;
  endfunction

  assign bus.dm_rdata = bus.dm_rd ? mem[bus.dm_addr] : 32'h0;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = seed_word(i);
    forever begin
      @(posedge clk);
      if (bus.dm_wr) mem[bus.dm_addr] <= bus.dm_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          g0, g1, st0, rd, wr, rv0, rv1;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rd0, rd1;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare every presented cycle response against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("p0_gnt",    32'(bus.p0_gnt),    32'(e.g0));
        chk("p1_gnt",    32'(bus.p1_gnt),    32'(e.g1));
        chk("p0_stall",  32'(bus.p0_stall),  32'(e.st0));
        chk("dm_rd",     32'(bus.dm_rd),     32'(e.rd));
        chk("dm_wr",     32'(bus.dm_wr),     32'(e.wr));
        chk("dm_addr",   32'(bus.dm_addr),   32'(e.addr));
        chk("dm_wdata",  bus.dm_wdata,       e.wdata);
        chk("p0_rvalid", 32'(bus.p0_rvalid), 32'(e.rv0));
        chk("p1_rvalid", 32'(bus.p1_rvalid), 32'(e.rv1));
        chk("p0_rdata",  bus.p0_rdata,       e.rd0);
        chk("p1_rdata",  bus.p1_rdata,       e.rd1);
      end
    end
  end

  // ---------------- reference model ----------------
  // Described in terms of "how long has port 1 been refused", "is a burst in
  // progress and how many locked beats has it had", and "did the last burst end
  // by force".
  logic [DW-1:0] ref_mem [0:127];
  int   m_denied;
  bit   m_in_burst;
  int   m_beats;
  bit   m_released;
  bit   m_rv0, m_rv1;
  logic [DW-1:0] m_hold0, m_hold1;

  task automatic model_reset();
    m_denied = 0; m_in_burst = 1'b0; m_beats = 0; m_released = 1'b0;
    m_rv0 = 1'b0; m_rv1 = 1'b0; m_hold0 = '0; m_hold1 = '0;
  endtask

  task automatic model_step(input bit r, input bit q0, input bit w0, input logic [AW-1:0] a0,
                            input logic [DW-1:0] d0, input bit q1, input bit w1,
                            input logic [AW-1:0] a1, input logic [DW-1:0] d1, input bit lk);
    exp_t e;
    bit g0, g1, forced;
    e = '{default: 0};
    if (r) begin
      model_reset();
    end else begin
      g1 = q1 && (m_denied == MAX_WAIT || m_in_burst || !q0);
      g0 = q0 && !g1;
      e.g0 = g0; e.g1 = g1; e.st0 = q0 && !g0;
      if (g0) begin e.rd = !w0; e.wr = w0; e.addr = a0; e.wdata = d0; end
      if (g1) begin e.rd = !w1; e.wr = w1; e.addr = a1; e.wdata = d1; end
      e.rv0 = m_rv0; e.rv1 = m_rv1; e.rd0 = m_hold0; e.rd1 = m_hold1;
      // advance to the next cycle
      m_rv0 = g0 && !w0;
      m_rv1 = g1 && !w1;
      if (m_rv0) m_hold0 = ref_mem[a0];
      if (m_rv1) m_hold1 = ref_mem[a1];
      if (g0 && w0) ref_mem[a0] = d0;
      if (g1 && w1) ref_mem[a1] = d1;
      if (q1 && !g1) m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
      else m_denied = 0;
      forced = 1'b0;
      if (m_in_burst) begin
        if (!q1 || !lk) begin
          m_in_burst = 1'b0; m_beats = 0;
        end else if (m_beats == BURST_MAX) begin
          m_in_burst = 1'b0; m_beats = 0; forced = 1'b1;
        end else begin
          m_beats++;
        end
      end else if (g1 && lk && !(m_released && q0)) begin
        m_in_burst = 1'b1; m_beats = 1;
      end
      m_released = forced;
    end
    exp_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit q0, input bit w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input bit q1, input bit w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1, input bit lk);
    bus.p0_req = q0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = q1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
    bus.p1_lock = lk;
    rst = r;
  endtask

  task automatic apply(input bit r, input bit q0, input bit w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input bit q1, input bit w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1, input bit lk);
    @(posedge clk);
    #1;
    drive(r, q0, w0, a0, d0, q1, w1, a1, d1, lk);
    model_step(r, q0, w0, a0, d0, q1, w1, a1, d1, lk);
  endtask

  // Reset asserted between clocks while a burst is running.
  task automatic reset_mid_burst();
    exp_t z;
    for (int i = 0; i < 3; i++)
      apply(1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0, 7'(7'h20 + i), 32'h0, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b0, 7'h01, 32'h0, 1'b1, 1'b0, 7'h30, 32'h0, 1'b1);
    z = '{default: 0};
    exp_q.push_back(z);
    #1;
    chk("pre_reset_p1_gnt", 32'(bus.p1_gnt), 32'h1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_p1_gnt", 32'(bus.p1_gnt), 32'h0);
    chk("async_rst_dm_rd",  32'(bus.dm_rd),  32'h0);
    apply(1'b1, 1'b1, 1'b0, 7'h01, 32'h0, 1'b1, 1'b0, 7'h30, 32'h0, 1'b1);
    // after release port 0 must win: no leftover lock or starvation credit
    for (int i = 0; i < 6; i++)
      apply(1'b0, 1'b1, 1'b0, 7'(i), 32'h0, 1'b1, 1'b0, 7'h31, 32'h0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = seed_word(i);
    model_reset();
    drive(1'b1, 1'b1, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0, 7'h00, 32'h0, 1'b0);

    // reset held with both requesting, then release
    apply(1'b1, 1'b1, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0, 7'h00, 32'h0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0, 7'h00, 32'h0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);

    // port 0 read latency on address 0x05, then idle cycles
    apply(1'b0, 1'b1, 1'b0, 7'h05, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);

    // starvation: both requesting without lock
    for (int i = 0; i < 12; i++)
      apply(1'b0, 1'b1, 1'b0, 7'(i), 32'h0, 1'b1, 1'b0, 7'(7'h40 + i), 32'h0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);

    // burst with port 0 requesting throughout
    for (int i = 0; i < 24; i++)
      apply(1'b0, 1'b1, 1'b0, 7'(i), 32'h0, 1'b1, 1'b0, 7'(7'h50 + i), 32'h0, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);

    // write isolation on port 1, then read it back through port 0
    apply(1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b1, 7'h10, 32'h0102_0304, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 7'h10, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);

    reset_mid_burst();

    // randomized traffic, occasional reset
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom % 400) == 0,
            ($urandom % 4) != 0, $urandom % 2, 7'($urandom), $urandom,
            ($urandom % 3) != 0, $urandom % 2, 7'($urandom), $urandom,
            ($urandom % 4) != 0);
    end
    apply(1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
